// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: RV32IM control decode registered into the ID/EX stage.
// Valid/ready handshake, flush, one-bubble load-use interlock and a
// saturating count of inserted bubbles.
module ctrl_decode_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ALUCTRL_WIDTH = 5,
    parameter int BRANCH_WIDTH  = 5,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    instruction,
    input  logic [DATA_WIDTH-1:0]    pc_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    pc_out,
    output logic [4:0]               rd,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [ALUCTRL_WIDTH-1:0] alu_ctr,
    output logic [BRANCH_WIDTH-1:0]  branch_ctr,
    output logic                     is_branch,
    output logic [2:0]               imm_src,
    output logic [1:0]               op1_src,
    output logic                     op2_src,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     reg_write,
    output logic [1:0]               wb_src,
    output logic                     illegal,
    output logic [CNT_WIDTH-1:0]     stall_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    pc;
        logic [4:0]               rd;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [ALUCTRL_WIDTH-1:0] alu_ctr;
        logic [BRANCH_WIDTH-1:0]  branch_ctr;
        logic                     is_branch;
        logic [2:0]               imm_src;
        logic [1:0]               op1_src;
        logic                     op2_src;
        logic                     mem_read;
        logic                     mem_write;
        logic                     reg_write;
        logic [1:0]               wb_src;
        logic                     illegal;
    } ctrl_t;

    ctrl_t      dec;
    ctrl_t      ctrl_q;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7_0;
    logic       f7_5;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       hz;
    logic       unused_bits;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign f7_0   = instruction[25];
    assign f7_5   = instruction[30];

    // Only funct7 bits 0 and 5 matter for RV32IM ALU selection.
    assign unused_bits = ^{instruction[DATA_WIDTH-1:31], instruction[29:26]};

    // Combinational decode of the incoming instruction.
    always_comb begin
        dec        = '0;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b0;
        dec.pc     = pc_in;
        dec.rd     = instruction[11:7];
        dec.rs1    = instruction[19:15];
        dec.rs2    = instruction[24:20];
        case (opcode)
            OP_R: begin
                dec.alu_ctr   = ALUCTRL_WIDTH'({f7_0, f7_5, funct3});
                dec.reg_write = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_IMM: begin
                // Only shifts-right use funct7[5] (SRAI vs SRLI); others carry imm bits there.
                dec.alu_ctr   = ALUCTRL_WIDTH'({1'b0, (funct3 == 3'b101) & f7_5, funct3});
                dec.op2_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_LOAD: begin
                dec.op2_src   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_src    = 2'd1;
            end
            OP_STORE: begin
                dec.imm_src   = 3'd1;
                dec.op2_src   = 1'b1;
                dec.mem_write = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                dec.alu_ctr    = ALUCTRL_WIDTH'(5'b01000);
                dec.branch_ctr = BRANCH_WIDTH'({2'b00, funct3});
                dec.is_branch  = 1'b1;
                dec.imm_src    = 3'd2;
                uses_rs2       = 1'b1;
            end
            OP_JAL: begin
                dec.branch_ctr = BRANCH_WIDTH'({2'b01, funct3});
                dec.imm_src    = 3'd4;
                dec.op1_src    = 2'd1;
                dec.op2_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.wb_src     = 2'd2;
                uses_rs1       = 1'b0;
            end
            OP_JALR: begin
                dec.branch_ctr = BRANCH_WIDTH'({2'b10, funct3});
                dec.op2_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.wb_src     = 2'd2;
            end
            OP_LUI: begin
                dec.imm_src   = 3'd3;
                dec.op1_src   = 2'd2;
                dec.op2_src   = 1'b1;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b0;
            end
            OP_AUIPC: begin
                dec.imm_src   = 3'd3;
                dec.op1_src   = 2'd1;
                dec.op2_src   = 1'b1;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b0;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.rd == 5'd0)
            dec.reg_write = 1'b0;
    end

    // Load in ID/EX whose destination is read by the instruction waiting in IF/ID.
    assign hz = out_valid & ctrl_q.mem_read & (ctrl_q.rd != 5'd0) & in_valid &
                ((uses_rs1 & (ctrl_q.rd == dec.rs1)) | (uses_rs2 & (ctrl_q.rd == dec.rs2)));

    assign in_ready = !rst & !flush & !hz & (!out_valid | out_ready);

    // ID/EX register: flush > bubble > accept > drain > hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            ctrl_q      <= '0;
            stall_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
        end else if (hz && out_ready) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
            if (stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            ctrl_q    <= dec;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
        end
    end

    assign pc_out     = ctrl_q.pc;
    assign rd         = ctrl_q.rd;
    assign rs1        = ctrl_q.rs1;
    assign rs2        = ctrl_q.rs2;
    assign alu_ctr    = ctrl_q.alu_ctr;
    assign branch_ctr = ctrl_q.branch_ctr;
    assign is_branch  = ctrl_q.is_branch;
    assign imm_src    = ctrl_q.imm_src;
    assign op1_src    = ctrl_q.op1_src;
    assign op2_src    = ctrl_q.op2_src;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign reg_write  = ctrl_q.reg_write;
    assign wb_src     = ctrl_q.wb_src;
    assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: accepted instructions push their
// hand-decoded controls; a negedge monitor pops and compares on each handshake.
module tb_ctrl_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  alu;
        logic [4:0]  br;
        logic        isb;
        logic [2:0]  imm;
        logic [1:0]  op1;
        logic        op2;
        logic        mr;
        logic        mw;
        logic        rw;
        logic [1:0]  wb;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [4:0]  rd, rs1, rs2;
    logic [4:0]  alu_ctr, branch_ctr;
    logic        is_branch;
    logic [2:0]  imm_src;
    logic [1:0]  op1_src;
    logic        op2_src;
    logic        mem_read, mem_write, reg_write;
    logic [1:0]  wb_src;
    logic        illegal;
    logic [31:0] stall_count;

    exp_t act;
    exp_t mon_e;
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    ctrl_decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .rd(rd), .rs1(rs1), .rs2(rs2),
        .alu_ctr(alu_ctr), .branch_ctr(branch_ctr), .is_branch(is_branch),
        .imm_src(imm_src), .op1_src(op1_src), .op2_src(op2_src),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .wb_src(wb_src), .illegal(illegal), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    assign act = {pc_out, rd, rs1, rs2, alu_ctr, branch_ctr, is_branch, imm_src,
                  op1_src, op2_src, mem_read, mem_write, reg_write, wb_src, illegal};

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] d, s1, s2, alu, br,
                                input logic isb, input logic [2:0] imm, input logic [1:0] op1,
                                input logic op2, mr, mw, rw, input logic [1:0] wb, input logic ill);
        return {pc, d, s1, s2, alu, br, isb, imm, op1, op2, mr, mw, rw, wb, ill};
    endfunction

    task automatic chk(input string name, input logic [69:0] got, input logic [69:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Drive one instruction and wait (bounded) for it to be accepted.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
        bit done = 1'b0;
        instruction = ins;
        pc_in       = pc;
        in_valid    = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                sb.push_back(e);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout pc=%h got=no_accept exp=accept", pc);
        end
    endtask

    // Monitor: every handshake on the output side must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL mon_unexpected got=%h exp=none", act);
            end else begin
                mon_e = sb.pop_front();
                if (act !== mon_e) begin
                    fails++;
                    $display("FAIL mon_pkt got=%h exp=%h", act, mon_e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instruction = 32'h0; pc_in = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_outputs", act, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Back-to-back ALU ops, OP-IMM shift, JAL
        send(32'h002081B3, 32'h100, mk(32'h100, 3, 1, 2, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        send(32'h402081B3, 32'h104, mk(32'h104, 3, 1, 2, 5'b01000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        send(32'h4030D393, 32'h108, mk(32'h108, 7, 1, 3, 5'b01101, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        send(32'h008000EF, 32'h10C, mk(32'h10C, 1, 0, 8, 5'b00000, 5'b01000, 0, 4, 1, 1, 0, 0, 1, 2, 0));

        // Load-use: one bubble, then the dependent add
        send(32'h0000A283, 32'h110, mk(32'h110, 5, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        instruction = 32'h00528333; pc_in = 32'h114; in_valid = 1'b1;
        @(negedge clk);
        chk("hz_in_ready", in_ready, 0);
        chk("hz_load_valid", out_valid, 1);
        @(negedge clk);
        chk("bubble_out_valid", out_valid, 0);
        chk("bubble_in_ready", in_ready, 1);
        @(posedge clk);
        sb.push_back(mk(32'h114, 6, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("stall_count_1", stall_count, 1);
        @(posedge clk); #1;

        // Branch held under back-pressure
        out_ready = 1'b0;
        send(32'h00208463, 32'h120, mk(32'h120, 8, 1, 2, 5'b01000, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_outputs", act, mk(32'h120, 8, 1, 2, 5'b01000, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;

        // Flush with a held load and a new instruction presented
        out_ready = 1'b0;
        send(32'h0000A283, 32'h130, mk(32'h130, 5, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        instruction = 32'h002081B3; pc_in = 32'h134; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        void'(sb.pop_back());
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        @(negedge clk);
        chk("flush_no_ghost", out_valid, 0);
        @(posedge clk); #1 out_ready = 1'b1;

        // Illegal opcode and LUI to x0
        send(32'h00000FFF, 32'h200, mk(32'h200, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        send(32'h12345037, 32'h204, mk(32'h204, 0, 8, 3, 0, 0, 0, 3, 2, 1, 0, 0, 0, 0, 0));
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        chk("stall_count_final", stall_count, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
